// File: rtl/alu_pkg.sv
// Opcodes, FSM state type and op-class helper shared by the sequential ALU.
// ALU_SRA_EN adds the arithmetic-right-shift opcode.
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND   = 5'd0;
  localparam logic [OP_W-1:0] OP_OR    = 5'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd4;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd6;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd7;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd8;
  localparam logic [OP_W-1:0] OP_LUI   = 5'd9;
  localparam logic [OP_W-1:0] OP_ADDU  = 5'd10;
  localparam logic [OP_W-1:0] OP_SUBU  = 5'd11;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd12;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd13;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd14;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd15;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'd16;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'd17;
`ifdef ALU_SRA_EN
  localparam logic [OP_W-1:0] OP_SRA   = 5'd18;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative magnitude multiplier / restoring divider, one bit per run cycle,
// with combinational sign fix-up of the finished HI/LO pair.
module alu_muldiv_core #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0]   acc, q, mb;
  logic [SHAMT_W-1:0] cnt;
  logic               div_q, neg_lo, neg_hi, dbz_q;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     add_sum, rem_try, rem_sub;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign a_neg = is_signed && a[WIDTH-1];
  assign b_neg = is_signed && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign addend  = q[0] ? mb : '0;
  assign add_sum = {1'b0, acc} + {1'b0, addend};

  // acc < mb always holds, so the top bit of rem_sub is a clean borrow flag
  assign rem_try = {acc, q[WIDTH-1]};
  assign rem_sub = rem_try - {1'b0, mb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      q      <= '0;
      mb     <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (start) begin
      cnt   <= SHAMT_W'(WIDTH - 1);
      div_q <= is_div;
      dbz_q <= 1'b0;
      acc   <= '0;
      q     <= a_mag;
      mb    <= b_mag;
      if (is_div && (b == '0)) begin
        dbz_q  <= 1'b1;
        acc    <= a;
        q      <= '1;
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
      end else if (is_div) begin
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg;
      end else begin
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg ^ b_neg;
      end
    end else if (run) begin
      if (cnt != '0) cnt <= cnt - SHAMT_W'(1);
      if (div_q) begin
        if (!rem_sub[WIDTH]) {acc, q} <= {rem_sub[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        else                 {acc, q} <= {rem_try[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
      end else begin
        {acc, q} <= {add_sum, q[WIDTH-1:1]};
      end
    end
  end

  assign last     = (cnt == '0);
  assign dbz      = dbz_q;
  assign prod     = {acc, q};
  assign prod_neg = -prod;

  // Multiply negates the full double-width product; divide fixes quotient and remainder separately
  always_comb begin
    hi = acc;
    lo = q;
    if (!div_q) begin
      if (neg_lo) {hi, lo} = prod_neg;
    end else begin
      if (neg_lo) lo = -q;
      if (neg_hi) hi = -acc;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with iterative MULT/DIV into architectural HI/LO, valid/ready towards issue.
// Optional ALU_SRA_EN macro adds op 18 (arithmetic right shift of b by shamt).
//
//   state | meaning
//   IDLE  | accepting ops; single-cycle results registered at the accept edge
//   RUN   | muldiv core iterating, one bit per cycle for WIDTH cycles
//   FIX   | sign-corrected HI/LO written, out_valid raised at the next edge
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               busy
);

  state_t           state, state_nxt;
  logic             accept, is_md, md_div, md_signed;
  logic             start, run, core_last, core_dbz;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign is_md     = is_muldiv(op);
  assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign md_signed = (op == OP_MULT) || (op == OP_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    run       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_md) begin
          start     = 1'b1;
          state_nxt = (md_div && (b == '0)) ? FIX : RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (core_last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_muldiv_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (run),
    .is_div    (md_div),
    .is_signed (md_signed),
    .a         (a),
    .b         (b),
    .last      (core_last),
    .dbz       (core_dbz),
    .hi        (core_hi),
    .lo        (core_lo)
  );

  assign sum  = a + b;
  assign diff = a - b;

  // Overflow looks only at this op's operands and its own sum/difference
  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  alu_res = ~(a | b);
      OP_LUI:  alu_res = b << (WIDTH / 2);
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = diff;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
`ifdef ALU_SRA_EN
      OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
`endif
      default: alu_res = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_md) begin
        out_valid   <= 1'b1;
        result      <= alu_res;
        zero        <= (alu_res == '0);
        overflow    <= alu_ovf;
        div_by_zero <= 1'b0;
      end else if (state == FIX) begin
        out_valid   <= 1'b1;
        hi          <= core_hi;
        lo          <= core_lo;
        result      <= core_lo;
        zero        <= (core_lo == '0);
        overflow    <= 1'b0;
        div_by_zero <= core_dbz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: arithmetic reference model, directed corner cases,
// latency/reset checks and randomized traffic.
module tb_alu_seq_muldiv;
  import alu_pkg::*;

  logic        clk, rst_n, in_valid, in_ready;
  logic [4:0]  op, shamt;
  logic [31:0] a, b, result;
  logic        out_valid, zero, overflow, div_by_zero, busy;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mhi, mlo;
  int          checks = 0;
  int          failures = 0;

  alu_seq_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definition
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sh);
    exp_t        e;
    int          sa, sb, lo32;
    longint      t;
    logic [63:0] u;
    sa = av;
    sb = bv;
    e.res = av + bv;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    case (o)
      5'd0:  e.res = av & bv;
      5'd1:  e.res = av | bv;
      5'd2:  begin t = longint'(sa) + longint'(sb); lo32 = int'(t); e.res = lo32; e.ovf = (longint'(lo32) != t); end
      5'd3:  begin t = longint'(sa) - longint'(sb); lo32 = int'(t); e.res = lo32; e.ovf = (longint'(lo32) != t); end
      5'd4:  e.res = bv << sh;
      5'd5:  e.res = bv >> sh;
      5'd6:  e.res = av ^ bv;
      5'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'd8:  e.res = ~(av | bv);
      5'd9:  e.res = bv << 16;
      5'd11: e.res = av - bv;
      5'd12: begin t = longint'(sa) * longint'(sb); mhi = t[63:32]; mlo = t[31:0]; e.res = mlo; end
      5'd13: begin u = {32'd0, av} * {32'd0, bv}; mhi = u[63:32]; mlo = u[31:0]; e.res = mlo; end
      5'd14, 5'd15: begin
        if (bv == 32'd0) begin
          mlo = 32'hFFFF_FFFF; mhi = av; e.dbz = 1'b1;
        end else if (o == 5'd15) begin
          mlo = av / bv; mhi = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000; mhi = 32'd0;
        end else begin
          mlo = sa / sb; mhi = sa % sb;
        end
        e.res = mlo;
      end
      5'd16: e.res = mhi;
      5'd17: e.res = mlo;
`ifdef ALU_SRA_EN
      5'd18: e.res = 32'(sb >>> sh);
`endif
      default: e.res = av + bv;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("issue_ready_wait", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    op = o; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    sbq.push_back(model(o, av, bv, sh));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge to the out_valid pulse and busy cycles in between
  task automatic measure(input int exp_lat, input int exp_low, input string nm);
    int n = 0;
    int low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 200);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_ready_low"}, 32'(low), 32'(exp_low));
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=%h required=none", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("zero", 32'(zero), 32'(e.res == 32'd0));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  function automatic logic [31:0] rand_val();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'(($urandom % 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [4:0] ro;
    in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    mhi = '0; mlo = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    issue(OP_SUB, 32'd5, 32'd5, 5'd0);
    issue(OP_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    issue(OP_SUB, 32'h8000_0000, 32'd1, 5'd0);
    issue(OP_LUI, 32'd0, 32'h0000_ABCD, 5'd0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
    measure(34, 33, "mult");
    issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd0);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    measure(34, 33, "div");
    issue(OP_MFLO, 32'd0, 32'd0, 5'd0);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd0);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    issue(OP_MFHI, 32'd0, 32'd0, 5'd0);

    issue(OP_DIVU, 32'd9, 32'd0, 5'd0);
    measure(2, 1, "divu_dbz");
    issue(OP_MFHI, 32'd0, 32'd0, 5'd0);

    issue(5'd18, 32'h0000_1234, 32'h8000_0000, 5'd4);

    // Reset in the middle of a multiply: no result, HI/LO stay at reset value
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    mhi = '0;
    mlo = '0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) ro = 5'(12 + ($urandom % 6));
      else                   ro = 5'($urandom % 32);
      issue(ro, rand_val(), rand_val(), 5'($urandom % 32));
      if ($urandom % 5 == 0) @(negedge clk);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
